// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared audio sample types for the I2S transmit path
package i2s_pkg;

    localparam int I2S_WORD_W = 32;

    typedef logic [I2S_WORD_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/i2s_pair_mem.sv
// rtl/i2s_pair_mem.sv - DEPTH x stereo pair storage, sync write, comb read
module i2s_pair_mem
    import i2s_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  stereo_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output stereo_t       rdata_o
);

    stereo_t mem_q [DEPTH];

    // Contents need no reset: only entries behind a valid level are ever read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - stereo pair FIFO feeding the I2S master transmitter
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LWM   = DEPTH / 2
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [I2S_WORD_W-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    data_rqst,
    output logic [I2S_WORD_W-1:0]   data_left,
    output logic [I2S_WORD_W-1:0]   data_right,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    lowwater,
    output logic                    overrun,
    output logic                    underrun,
    input  logic                    clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic LWM_AT_RESET = (LWM > 0);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_ch_q, wr_ch_d;
    sample_t       left_hold_q, left_hold_d;
    stereo_t       data_q, data_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          lowwater_q, lowwater_d;
    logic          overrun_q, overrun_d;
    logic          underrun_q, underrun_d;

    logic    accept, commit, drop, pop_ok, pop_empty;
    stereo_t rd_pair;
    stereo_t wr_pair;

    // Flush swallows any same-cycle write or pop, including their error flags.
    assign accept    = wr_en && !full_q && !flush;
    assign commit    = accept && wr_ch_q;
    assign drop      = wr_en && full_q && !flush;
    assign pop_ok    = data_rqst && !empty_q && !flush;
    assign pop_empty = data_rqst && empty_q && !flush;

    assign wr_pair.left  = left_hold_q;
    assign wr_pair.right = wr_data;

    i2s_pair_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (commit),
        .waddr_i (wptr_q),
        .wdata_i (wr_pair),
        .raddr_i (rptr_q),
        .rdata_o (rd_pair)
    );

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        wr_ch_d     = wr_ch_q;
        left_hold_d = left_hold_q;
        data_d      = data_q;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            wr_ch_d     = 1'b0;
            left_hold_d = '0;
            data_d      = '0;
        end else begin
            if (accept) begin
                if (!wr_ch_q) begin
                    left_hold_d = wr_data;
                    wr_ch_d     = 1'b1;
                end else begin
                    wptr_d  = wptr_q + AW'(1);
                    wr_ch_d = 1'b0;
                end
            end
            if (pop_ok) begin
                data_d = rd_pair;
                rptr_d = rptr_q + AW'(1);
            end else if (pop_empty) begin
                data_d = '0;
            end
            case ({commit, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        full_d     = (level_d == LW'(DEPTH));
        empty_d    = (level_d == '0);
        lowwater_d = (level_d < LW'(LWM));
        overrun_d  = drop || (overrun_q && !clr_err);
        underrun_d = pop_empty || (underrun_q && !clr_err);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            wr_ch_q     <= 1'b0;
            left_hold_q <= '0;
            data_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            lowwater_q  <= LWM_AT_RESET;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            wr_ch_q     <= wr_ch_d;
            left_hold_q <= left_hold_d;
            data_q      <= data_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            lowwater_q  <= lowwater_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    assign wr_ready   = !full_q;
    assign data_left  = data_q.left;
    assign data_right = data_q.right;
    assign level      = level_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign lowwater   = lowwater_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb/tb_i2s_tx_fifo.sv - directed self-checking bench for i2s_tx_fifo
`timescale 1ns/1ps
module tb_i2s_tx_fifo;

    logic        clk;
    logic        nrst;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        data_rqst;
    logic [31:0] data_left;
    logic [31:0] data_right;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        lowwater;
    logic        overrun;
    logic        underrun;
    logic        clr_err;

    int vectors;
    int miscompares;

    i2s_tx_fifo #(.DEPTH(8), .LWM(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .data_rqst  (data_rqst),
        .data_left  (data_left),
        .data_right (data_right),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .lowwater   (lowwater),
        .overrun    (overrun),
        .underrun   (underrun),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic pop_pair();
        data_rqst = 1'b1;
        tick();
        data_rqst = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
        data_rqst = 1'b0; clr_err = 1'b0;
        tick(); tick();
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
        vectors++; if ({empty, lowwater, full, wr_ready} !== 4'b1101) begin miscompares++; $display("FAIL reset_flags got %b want 1101", {empty, lowwater, full, wr_ready}); end
        vectors++; if ({data_left, data_right} !== 64'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", {data_left, data_right}); end
        vectors++; if ({overrun, underrun} !== 2'b00) begin miscompares++; $display("FAIL reset_sticky got %b want 00", {overrun, underrun}); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic_order();
        write_word(32'h11111111); write_word(32'h22222222);
        write_word(32'h33333333); write_word(32'h44444444);
        vectors++; if (level !== 4'd2) begin miscompares++; $display("FAIL basic_level2 got %0d want 2", level); end
        pop_pair();
        vectors++; if ({data_left, data_right} !== 64'h11111111_22222222) begin miscompares++; $display("FAIL basic_pop1 got %h want 1111111122222222", {data_left, data_right}); end
        vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL basic_level1 got %0d want 1", level); end
        pop_pair();
        vectors++; if ({data_left, data_right} !== 64'h33333333_44444444) begin miscompares++; $display("FAIL basic_pop2 got %h want 3333333344444444", {data_left, data_right}); end
        vectors++; if (level !== 4'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL basic_level0 got %0d/%b want 0/1", level, empty); end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 16; i++) write_word(32'h1000 + i);
        vectors++; if ({full, wr_ready, lowwater} !== 3'b100) begin miscompares++; $display("FAIL fill_flags got %b want 100", {full, wr_ready, lowwater}); end
        vectors++; if (level !== 4'd8 || overrun !== 1'b0) begin miscompares++; $display("FAIL fill_level got %0d/%b want 8/0", level, overrun); end
        write_word(32'hDEADBEEF);
        vectors++; if (overrun !== 1'b1 || level !== 4'd8) begin miscompares++; $display("FAIL fill_overrun got %b/%0d want 1/8", overrun, level); end
        for (int k = 0; k < 8; k++) begin
            pop_pair();
            vectors++;
            if (data_left !== 32'h1000 + 2*k || data_right !== 32'h1000 + 2*k + 1) begin
                miscompares++;
                $display("FAIL fill_pop%0d got %h/%h want %h/%h", k, data_left, data_right, 32'h1000 + 2*k, 32'h1000 + 2*k + 1);
            end
        end
        vectors++; if (empty !== 1'b1 || level !== 4'd0) begin miscompares++; $display("FAIL fill_drain got %b/%0d want 1/0", empty, level); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL fill_clr got %b want 0", overrun); end
    endtask

    task automatic test_underrun();
        pop_pair();
        vectors++; if ({data_left, data_right} !== 64'h0 || underrun !== 1'b1) begin miscompares++; $display("FAIL under_mute got %h/%b want 0/1", {data_left, data_right}, underrun); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL under_clr got %b want 0", underrun); end
        clr_err = 1'b1; data_rqst = 1'b1; tick(); clr_err = 1'b0; data_rqst = 1'b0;
        vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL under_setwins got %b want 1", underrun); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    task automatic test_commit_and_pop();
        for (int i = 0; i < 6; i++) write_word(32'hA0 + i);
        vectors++; if (level !== 4'd3 || lowwater !== 1'b1) begin miscompares++; $display("FAIL simul_pre got %0d/%b want 3/1", level, lowwater); end
        write_word(32'hB0);
        wr_en = 1'b1; wr_data = 32'hB1; data_rqst = 1'b1;
        tick();
        wr_en = 1'b0; wr_data = '0; data_rqst = 1'b0;
        vectors++; if (level !== 4'd3) begin miscompares++; $display("FAIL simul_level got %0d want 3", level); end
        vectors++; if ({data_left, data_right} !== {32'hA0, 32'hA1}) begin miscompares++; $display("FAIL simul_oldest got %h want a0/a1", {data_left, data_right}); end
        pop_pair(); pop_pair(); pop_pair();
        vectors++; if ({data_left, data_right} !== {32'hB0, 32'hB1} || level !== 4'd0) begin miscompares++; $display("FAIL simul_last got %h/%0d want b0b1/0", {data_left, data_right}, level); end
    endtask

    task automatic test_flush();
        write_word(32'hDEAD0001);
        flush = 1'b1; wr_en = 1'b1; wr_data = 32'h5555; data_rqst = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0; wr_data = '0; data_rqst = 1'b0;
        vectors++; if ({data_left, data_right} !== 64'h0 || level !== 4'd0) begin miscompares++; $display("FAIL flush_clear got %h/%0d want 0/0", {data_left, data_right}, level); end
        vectors++; if ({overrun, underrun} !== 2'b00) begin miscompares++; $display("FAIL flush_noflag got %b want 00", {overrun, underrun}); end
        write_word(32'hAAAA0000); write_word(32'hBBBB0000);
        vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL flush_level got %0d want 1", level); end
        pop_pair();
        vectors++; if ({data_left, data_right} !== 64'hAAAA0000_BBBB0000) begin miscompares++; $display("FAIL flush_toggle got %h want aaaa0000bbbb0000", {data_left, data_right}); end
    endtask

    task automatic test_async_reset();
        pop_pair();
        for (int i = 0; i < 10; i++) write_word(32'hC000 + i);
        pop_pair();
        write_word(32'hC00A); write_word(32'hC00B);
        write_word(32'hCCCC);
        vectors++; if (level !== 4'd5 || underrun !== 1'b1) begin miscompares++; $display("FAIL arst_pre got %0d/%b want 5/1", level, underrun); end
        #2 nrst = 1'b0;
        #1;
        vectors++; if (level !== 4'd0 || {empty, lowwater, full, wr_ready} !== 4'b1101) begin miscompares++; $display("FAIL arst_flags got %0d/%b want 0/1101", level, {empty, lowwater, full, wr_ready}); end
        vectors++; if ({data_left, data_right} !== 64'h0 || {overrun, underrun} !== 2'b00) begin miscompares++; $display("FAIL arst_data got %h/%b want 0/00", {data_left, data_right}, {overrun, underrun}); end
        @(negedge clk); nrst = 1'b1;
        tick();
        write_word(32'hE1E1E1E1); write_word(32'hE2E2E2E2);
        pop_pair();
        vectors++; if ({data_left, data_right} !== 64'hE1E1E1E1_E2E2E2E2) begin miscompares++; $display("FAIL arst_left_first got %h want e1e1e1e1e2e2e2e2", {data_left, data_right}); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic_order();
        test_fill_full();
        test_underrun();
        test_commit_and_pop();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
